// File: rtl/game_flow_controller_pkg.sv
// Shared game-flow constants: state encodings and default tuning.
// Imported by the controller, its interface users and the bench.
package game_flow_controller_pkg;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    RUNNING     = 3'd1,
    DYING       = 3'd2,
    LEVEL_CLEAR = 3'd3,
    GAME_OVER   = 3'd4
  } state_t;

  localparam int DEF_NUM_LIVES    = 3;
  localparam int DEF_MAX_LEVEL    = 9;
  localparam int DEF_DEATH_FRAMES = 60;
  localparam int DEF_CLEAR_FRAMES = 30;

  function automatic logic is_paused(state_t s);
    return (s == DYING) || (s == LEVEL_CLEAR);
  endfunction

endpackage

// File: rtl/game_flow_controller_if.sv
// Control bundle between the game-flow controller and the
// switch, collision, frog and obstacle blocks.
interface game_flow_controller_if #(
  parameter int LIVES_WIDTH = 2,
  parameter int LEVEL_WIDTH = 4
);

  logic                   i_Frame_Tick;
  logic                   i_Start;
  logic                   i_Has_Collided;
  logic                   i_Reached_Goal;
  logic                   o_Game_Active;
  logic                   o_Frozen;
  logic                   o_Respawn;
  logic                   o_Level_Up;
  logic [LEVEL_WIDTH-1:0] o_Level;
  logic [LIVES_WIDTH-1:0] o_Lives;
  logic                   o_Game_Over;
  logic [2:0]             o_State;

  modport master (
    output i_Frame_Tick, i_Start,
    output i_Has_Collided, i_Reached_Goal,
    input  o_Game_Active, o_Frozen,
    input  o_Respawn, o_Level_Up,
    input  o_Level, o_Lives,
    input  o_Game_Over, o_State
  );

  modport slave (
    input  i_Frame_Tick, i_Start,
    input  i_Has_Collided, i_Reached_Goal,
    output o_Game_Active, o_Frozen,
    output o_Respawn, o_Level_Up,
    output o_Level, o_Lives,
    output o_Game_Over, o_State
  );

endinterface

// File: rtl/game_flow_controller_frame_timer.sv
// Loadable frame down-counter shared by the death and
// level-clear pauses; done fires on the tick taking it 1->0.
module game_flow_controller_frame_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             tick,
  output logic             done
);

  logic [WIDTH-1:0] count;

  // Load wins; otherwise count down per tick, holding at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (tick && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign done = tick && !load && (count == WIDTH'(1));

endmodule

// File: rtl/game_flow_controller.sv
// Frogger game-flow FSM: lives, levels, timed death and
// level-clear pauses, and game over.
module game_flow_controller
  import game_flow_controller_pkg::*;
#(
  parameter int NUM_LIVES    = DEF_NUM_LIVES,
  parameter int LIVES_WIDTH  = 2,
  parameter int MAX_LEVEL    = DEF_MAX_LEVEL,
  parameter int LEVEL_WIDTH  = 4,
  parameter int DEATH_FRAMES = DEF_DEATH_FRAMES,
  parameter int CLEAR_FRAMES = DEF_CLEAR_FRAMES,
  parameter int TIMER_WIDTH  = 8
) (
  input logic                  i_Clk,
  input logic                  i_Reset,
  game_flow_controller_if.slave bus
);

  state_t                 state;
  logic [LIVES_WIDTH-1:0] lives;
  logic [LEVEL_WIDTH-1:0] level;
  logic                   armed;
  logic                   respawn;
  logic                   level_up;
  logic                   start_ok;
  logic                   timer_load;
  logic [TIMER_WIDTH-1:0] timer_value;
  logic                   timer_tick;
  logic                   timer_done;

  // A start only counts after the switches have been seen released.
  assign start_ok = armed && bus.i_Start &&
                    ((state == IDLE) || (state == GAME_OVER));

  assign timer_tick = bus.i_Frame_Tick && is_paused(state);

  // Load the pause length as RUNNING hands off; collision wins.
  always_comb begin
    timer_load  = 1'b0;
    timer_value = TIMER_WIDTH'(CLEAR_FRAMES);
    if (state == RUNNING) begin
      if (bus.i_Has_Collided) begin
        timer_load  = 1'b1;
        timer_value = TIMER_WIDTH'(DEATH_FRAMES);
      end else if (bus.i_Reached_Goal) begin
        timer_load  = 1'b1;
      end
    end
  end

  game_flow_controller_frame_timer #(
    .WIDTH(TIMER_WIDTH)
  ) u_timer (
    .clk       (i_Clk),
    .rst       (i_Reset),
    .load      (timer_load),
    .load_value(timer_value),
    .tick      (timer_tick),
    .done      (timer_done)
  );

  // Game-flow state, lives, level, arming and transition pulses.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state    <= IDLE;
      lives    <= LIVES_WIDTH'(NUM_LIVES);
      level    <= LEVEL_WIDTH'(1);
      armed    <= 1'b0;
      respawn  <= 1'b0;
      level_up <= 1'b0;
    end else begin
      respawn  <= 1'b0;
      level_up <= 1'b0;
      if (start_ok) begin
        armed <= 1'b0;
      end else if (!bus.i_Start) begin
        armed <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (start_ok) begin
            state   <= RUNNING;
            respawn <= 1'b1;
          end
        end
        RUNNING: begin
          if (bus.i_Has_Collided) begin
            state <= DYING;
            if (lives != '0) begin
              lives <= lives - 1'b1;
            end
          end else if (bus.i_Reached_Goal) begin
            state <= LEVEL_CLEAR;
            if (level < LEVEL_WIDTH'(MAX_LEVEL)) begin
              level    <= level + 1'b1;
              level_up <= 1'b1;
            end
          end
        end
        DYING: begin
          if (timer_done) begin
            if (lives == '0) begin
              state <= GAME_OVER;
            end else begin
              state   <= RUNNING;
              respawn <= 1'b1;
            end
          end
        end
        LEVEL_CLEAR: begin
          if (timer_done) begin
            state   <= RUNNING;
            respawn <= 1'b1;
          end
        end
        GAME_OVER: begin
          if (start_ok) begin
            state <= IDLE;
            lives <= LIVES_WIDTH'(NUM_LIVES);
            level <= LEVEL_WIDTH'(1);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.o_Game_Active = (state == RUNNING);
  assign bus.o_Frozen      = is_paused(state) ||
                             (state == GAME_OVER);
  assign bus.o_Game_Over   = (state == GAME_OVER);
  assign bus.o_Respawn     = respawn;
  assign bus.o_Level_Up    = level_up;
  assign bus.o_Level       = level;
  assign bus.o_Lives       = lives;
  assign bus.o_State       = state;

endmodule

// File: tb/tb_game_flow_controller.sv
// Bench for game_flow_controller: vector table, directed
// corner sequences and random stimulus against a rule model.
module tb_game_flow_controller;
  import game_flow_controller_pkg::*;

  localparam int NL   = 3;
  localparam int MAXL = 9;
  localparam int DF   = 60;
  localparam int CF   = 30;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  game_flow_controller_if #(
    .LIVES_WIDTH(2),
    .LEVEL_WIDTH(4)
  ) bus ();

  game_flow_controller dut (
    .i_Clk  (clk),
    .i_Reset(rst),
    .bus    (bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  int lup_cnt     = 0;

  // Rule model: mode 0..4 = idle/run/dying/clear/over
  int m_mode;
  int m_lives;
  int m_level;
  int m_left;
  bit m_armed;
  bit e_resp;
  bit e_lup;

  typedef struct {
    bit s;
    bit c;
    bit g;
    bit t;
    int st;
    int lives;
    int level;
    int resp;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(string name, int got, int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d",
               name, got, exp);
    end
  endtask

  task automatic model_reset();
    m_mode  = 0;
    m_lives = NL;
    m_level = 1;
    m_left  = 0;
    m_armed = 1'b0;
    e_resp  = 1'b0;
    e_lup   = 1'b0;
  endtask

  task automatic model_step(bit s, bit c, bit g, bit t);
    bit ok;
    ok = m_armed && s && (m_mode == 0 || m_mode == 4);
    e_resp = 1'b0;
    e_lup  = 1'b0;
    if (ok) m_armed = 1'b0;
    else if (!s) m_armed = 1'b1;
    case (m_mode)
      0: if (ok) begin
        m_mode = 1;
        e_resp = 1'b1;
      end
      1: if (c) begin
        m_mode = 2;
        m_left = DF;
        if (m_lives > 0) m_lives--;
      end else if (g) begin
        m_mode = 3;
        m_left = CF;
        if (m_level < MAXL) begin
          m_level++;
          e_lup = 1'b1;
        end
      end
      2, 3: if (t) begin
        m_left--;
        if (m_left == 0) begin
          if (m_mode == 2 && m_lives == 0) begin
            m_mode = 4;
          end else begin
            m_mode = 1;
            e_resp = 1'b1;
          end
        end
      end
      4: if (ok) begin
        m_mode  = 0;
        m_lives = NL;
        m_level = 1;
      end
      default: m_mode = 0;
    endcase
  endtask

  task automatic check_model();
    chk("state", int'(bus.o_State), m_mode);
    chk("lives", int'(bus.o_Lives), m_lives);
    chk("level", int'(bus.o_Level), m_level);
    chk("respawn", int'(bus.o_Respawn), int'(e_resp));
    chk("level_up", int'(bus.o_Level_Up), int'(e_lup));
    chk("active", int'(bus.o_Game_Active),
        int'(m_mode == 1));
    chk("frozen", int'(bus.o_Frozen),
        int'(m_mode >= 2 && m_mode <= 4));
    chk("game_over", int'(bus.o_Game_Over),
        int'(m_mode == 4));
  endtask

  task automatic step(bit s, bit c, bit g, bit t);
    @(negedge clk);
    bus.i_Start        = s;
    bus.i_Has_Collided = c;
    bus.i_Reached_Goal = g;
    bus.i_Frame_Tick   = t;
    @(posedge clk);
    model_step(s, c, g, t);
    #1;
    check_model();
    if (bus.o_Level_Up) lup_cnt++;
  endtask

  task automatic do_reset(bit s);
    @(negedge clk);
    rst                = 1'b1;
    bus.i_Start        = s;
    bus.i_Has_Collided = 1'b0;
    bus.i_Reached_Goal = 1'b0;
    bus.i_Frame_Tick   = 1'b0;
    model_reset();
    #1;
    check_model();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic run_pause();
    for (int i = 0; i < 400 &&
         (m_mode == 2 || m_mode == 3); i++) begin
      step(1'b0, 1'b0, 1'b0, ($urandom % 2) == 1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 5; i++)
      tbl[i] = '{1, 0, 0, 0, 0, 3, 1, 0};
    tbl[5]  = '{0, 0, 0, 0, 0, 3, 1, 0};
    tbl[6]  = '{1, 0, 0, 0, 1, 3, 1, 1};
    tbl[7]  = '{0, 0, 0, 0, 1, 3, 1, 0};
    tbl[8]  = '{0, 1, 0, 0, 2, 2, 1, 0};
    tbl[9]  = '{0, 0, 1, 0, 2, 2, 1, 0};
    tbl[10] = '{0, 0, 0, 1, 2, 2, 1, 0};

    // Start held through reset must not launch a game.
    do_reset(1'b1);
    for (int i = 0; i < 11; i++) begin
      step(tbl[i].s, tbl[i].c, tbl[i].g, tbl[i].t);
      chk("tbl_state", int'(bus.o_State), tbl[i].st);
      chk("tbl_lives", int'(bus.o_Lives), tbl[i].lives);
      chk("tbl_level", int'(bus.o_Level), tbl[i].level);
      chk("tbl_respawn", int'(bus.o_Respawn), tbl[i].resp);
    end

    // Finish the death pause: 59 more ticks, gaps between.
    for (int i = 0; i < 300 && m_mode == 2; i++)
      step(1'b0, 1'b0, 1'b0, i[0]);
    chk("death_exit_state", int'(bus.o_State), 1);
    chk("death_exit_lives", int'(bus.o_Lives), 2);
    chk("death_exit_respawn", int'(bus.o_Respawn), 1);

    // Goal and collision together: collision wins.
    lup_cnt = 0;
    step(1'b0, 1'b1, 1'b1, 1'b0);
    chk("both_state", int'(bus.o_State), 2);
    chk("both_level", int'(bus.o_Level), 1);
    chk("both_level_up", lup_cnt, 0);
    run_pause();

    // Fresh game, then climb to the level ceiling.
    do_reset(1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("restart_state", int'(bus.o_State), 1);
    lup_cnt = 0;
    for (int k = 0; k < 9; k++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0);
      run_pause();
    end
    chk("level_max", int'(bus.o_Level), 9);
    chk("level_up_count", lup_cnt, 8);

    // Three deaths end the game.
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0);
      run_pause();
    end
    chk("over_state", int'(bus.o_State), 4);
    chk("over_flag", int'(bus.o_Game_Over), 1);
    chk("over_lives", int'(bus.o_Lives), 0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("over_to_idle", int'(bus.o_State), 0);
    chk("idle_lives", int'(bus.o_Lives), 3);
    chk("idle_level", int'(bus.o_Level), 1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("held_no_run", int'(bus.o_State), 0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("second_press", int'(bus.o_State), 1);

    // Reset in the middle of a death pause.
    step(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 300 && m_left > 25; i++)
      step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("pre_abort_state", int'(bus.o_State), 2);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_model();
    chk("abort_respawn", int'(bus.o_Respawn), 0);
    @(posedge clk);
    #1;
    check_model();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Random traffic against the rule model.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 8) == 0, ($urandom % 24) == 0,
           ($urandom % 16) == 0, ($urandom % 2) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/game_flow_controller.md
Name: game_flow_controller

Overview:
Parametrised game-flow state machine that replaces the two-state IDLE/RUNNING controller in the Frogger top level. It adds lives, levels, timed death and level-clear pauses, and a game-over state. It sits between the debounced switches, collision detection, character control and obstacle movement. It drives the game-active, freeze, respawn and level-up controls consumed by those blocks.

Parameters:
NUM_LIVES, 3, lives at game start; must be 1..(2^LIVES_WIDTH-1)
LIVES_WIDTH, 2, width of o_Lives
MAX_LEVEL, 9, highest level; the level saturates here; must be >=1
LEVEL_WIDTH, 4, width of o_Level; must satisfy MAX_LEVEL < 2^LEVEL_WIDTH
DEATH_FRAMES, 60, frame ticks spent in DYING; must be >=1
CLEAR_FRAMES, 30, frame ticks spent in LEVEL_CLEAR; must be >=1
TIMER_WIDTH, 8, pause timer width; must hold max(DEATH_FRAMES, CLEAR_FRAMES)

Ports:
i_Clk  in  1  system clock (25 MHz pixel clock)
i_Reset  in  1  asynchronous, active-high reset
i_Frame_Tick  in  1  one-cycle pulse per video frame (end of visible area)
i_Start  in  1  debounced start request: all four switches pressed together
i_Has_Collided  in  1  level-sensitive collision flag from collision detection
i_Reached_Goal  in  1  one-cycle pulse when the frog reaches the top row
o_Game_Active  out  1  high only in RUNNING; gates frog movement
o_Frozen  out  1  high in DYING, LEVEL_CLEAR, GAME_OVER; stalls obstacles
o_Respawn  out  1  one-cycle pulse: return the frog to its base position
o_Level_Up  out  1  one-cycle pulse when o_Level increments
o_Level  out  LEVEL_WIDTH  current level, 1-based
o_Lives  out  LIVES_WIDTH  remaining lives
o_Game_Over  out  1  high in GAME_OVER
o_State  out  3  state encoding, for debug and sprite selection

Behaviour:
- Reset (async assert, sync release): state=IDLE, o_Lives=NUM_LIVES, o_Level=1, timer=0, armed=0, all pulses 0. o_Game_Active=0, o_Frozen=0, o_Game_Over=0.
- Start arming: the armed flag sets on any cycle with i_Start=0. A start is accepted only when armed=1 and i_Start=1. Accepting a start clears armed. A switch combination held through reset or game over therefore cannot restart the game.
- States: IDLE=0, RUNNING=1, DYING=2, LEVEL_CLEAR=3, GAME_OVER=4. Unused encodings go to IDLE next cycle.
- IDLE -> RUNNING on an accepted start. The same cycle pulses o_Respawn.
- RUNNING -> DYING when i_Has_Collided=1. Timer loads DEATH_FRAMES. Lives decrement with saturation at 0.
- RUNNING -> LEVEL_CLEAR when i_Reached_Goal=1 and i_Has_Collided=0. Collision wins when both occur in the same cycle. Timer loads CLEAR_FRAMES.
- On entering LEVEL_CLEAR: if o_Level<MAX_LEVEL, o_Level increments and o_Level_Up pulses in the same cycle. At MAX_LEVEL the level holds and no pulse is issued.
- DYING and LEVEL_CLEAR: the timer decrements only on i_Frame_Tick. i_Has_Collided and i_Reached_Goal are ignored.
- DYING exit, on the tick where the timer goes 1->0: if lives=0 go to GAME_OVER, otherwise go to RUNNING with an o_Respawn pulse.
- LEVEL_CLEAR exit, on the tick where the timer goes 1->0: go to RUNNING with an o_Respawn pulse.
- GAME_OVER -> IDLE on an accepted start. The same cycle reloads o_Lives=NUM_LIVES and o_Level=1. A second accepted start is then needed to run.
- Latency: all outputs are registered. State and output changes appear one cycle after the triggering input sample.
- All outputs are Moore outputs decoded from registered state, except the pulses, which are registered alongside the transition.
- Asserting reset mid-pause aborts immediately to the reset values. No pulses are emitted.

Decomposition:
- Shared constants header: state encodings (IDLE..GAME_OVER) and the default NUM_LIVES, MAX_LEVEL, DEATH_FRAMES and CLEAR_FRAMES values, alongside the existing game constants.
- One natural sub-module: frame_timer. It is a loadable down-counter that decrements on a tick enable and emits a one-cycle done pulse on the 1->0 transition. It is reused for both DYING and LEVEL_CLEAR.

Test Plan:
- Reset with i_Start=1 held, then 5 cycles -> state stays IDLE. Release i_Start, then assert it -> next cycle RUNNING, o_Respawn=1 for 1 cycle, o_Lives=3, o_Level=1.
- In RUNNING, pulse i_Has_Collided, then 60 i_Frame_Ticks -> o_Lives=2 and o_Frozen=1 throughout. Returns to RUNNING with o_Respawn on the 60th tick.
- In RUNNING, assert i_Reached_Goal and i_Has_Collided in the same cycle -> DYING, o_Level unchanged at 1, no o_Level_Up.
- 9 goal pulses, each followed by 30 ticks -> o_Level reaches 9 with 8 o_Level_Up pulses. The 9th goal gives no pulse and the level stays 9.
- 3 collisions each run to timer expiry -> GAME_OVER, o_Game_Over=1, o_Lives=0. Start press -> IDLE with lives=3 and level=1. Second press -> RUNNING.
- Assert i_Reset mid-DYING at timer=25 -> IDLE immediately, all outputs at reset values, no o_Respawn.
